// File: rtl/controlador_pkg.sv
// Shared definitions for the tick-sequencer slice.
//   estado_t      : sequencer state encoding (also the visible estado output)
//   PRESCALE_DEF  : default clk cycles per tick
//   CUENTA_W_DEF  : default width of the programmed tick count
package controlador_pkg;

    localparam int unsigned PRESCALE_DEF = 28;
    localparam int unsigned CUENTA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CORRE = 2'b01,
        PAUSA = 2'b10,
        FIN   = 2'b11
    } estado_t;

endpackage

// File: rtl/controlador_temporizador_if.sv
// Control/status bundle between user control logic and the tick sequencer.
//   start, pausa, clear, carga : commands from the user side
//   tick, restante, ocupado,
//   fin, estado                : registered status from the sequencer
// master = user control logic, slave = controlador_temporizador.
interface controlador_temporizador_if
    import controlador_pkg::*;
#(
    parameter int unsigned CUENTA_W = CUENTA_W_DEF
);
    logic                start;
    logic                pausa;
    logic                clear;
    logic [CUENTA_W-1:0] carga;
    logic                tick;
    logic [CUENTA_W-1:0] restante;
    logic                ocupado;
    logic                fin;
    estado_t             estado;

    modport master (
        output start, pausa, clear, carga,
        input  tick, restante, ocupado, fin, estado
    );

    modport slave (
        input  start, pausa, clear, carga,
        output tick, restante, ocupado, fin, estado
    );
endinterface

// File: rtl/prescaler_tick.sv
// Modulo-PRESCALE up-counter producing the tick wrap condition.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable (counter holds its value while low)
//   clr        : synchronous clear to 0, wins over en
//   wrap       : high in the cycle the counter sits at PRESCALE-1 with en set;
//                the counter returns to 0 on that edge
module prescaler_tick #(
    parameter int unsigned PRESCALE = 28
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic wrap
);
    localparam int unsigned W = $clog2(PRESCALE);
    localparam logic [W-1:0] ULT = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    assign wrap = en && (cnt == ULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/controlador_temporizador.sv
// Sequencer for a programmable count-down of prescaler ticks.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : controlador_temporizador_if.slave
//                in : start, pausa, clear, carga
//                out: tick, restante, ocupado, fin, estado (all registered)
// Build option: AUTORELOAD_EN -- on reaching 0 while running, restante is
// reloaded from the last accepted carga and the sequencer keeps running.
module controlador_temporizador
    import controlador_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEF,
    parameter int unsigned CUENTA_W = CUENTA_W_DEF
) (
    input logic                       clk,
    input logic                       rst_n,
    controlador_temporizador_if.slave bus
);
    estado_t             estado, estado_n;
    logic [CUENTA_W-1:0] restante, restante_n;
    logic                tick_r, tick_n;
    logic                fin_r, fin_n;
    logic                ocupado_r, ocupado_n;
    logic                acepta, pre_en, pre_clr, wrap;
`ifdef AUTORELOAD_EN
    logic [CUENTA_W-1:0] carga_reg, carga_reg_n;
`endif

    // clear gates the prescaler enable so a coinciding wrap never ticks.
    assign acepta  = bus.start && !bus.clear && (estado == IDLE || estado == FIN);
    assign pre_en  = (estado == CORRE) && !bus.pausa && !bus.clear;
    assign pre_clr = bus.clear || acepta;

    prescaler_tick #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (pre_clr),
        .wrap  (wrap)
    );

    always_comb begin
        estado_n   = estado;
        restante_n = restante;
        tick_n     = 1'b0;
        fin_n      = 1'b0;
`ifdef AUTORELOAD_EN
        carga_reg_n = carga_reg;
`endif
        if (bus.clear) begin
            estado_n   = IDLE;
            restante_n = '0;
        end else begin
            unique case (estado)
                IDLE, FIN: begin
                    if (acepta) begin
`ifdef AUTORELOAD_EN
                        carga_reg_n = bus.carga;
`endif
                        if (bus.carga != '0) begin
                            estado_n   = CORRE;
                            restante_n = bus.carga;
                        end else begin
                            estado_n   = FIN;
                            restante_n = '0;
                            fin_n      = 1'b1;
                        end
                    end
                end
                CORRE: begin
                    if (bus.pausa) begin
                        estado_n = PAUSA;
                    end else if (wrap) begin
                        tick_n = 1'b1;
                        if (restante == CUENTA_W'(1)) begin
                            fin_n = 1'b1;
`ifdef AUTORELOAD_EN
                            restante_n = carga_reg;
`else
                            restante_n = '0;
                            estado_n   = FIN;
`endif
                        end else if (restante != '0) begin
                            restante_n = restante - 1'b1;
                        end
                    end
                end
                PAUSA: begin
                    if (!bus.pausa) begin
                        estado_n = CORRE;
                    end
                end
                default: estado_n = IDLE;
            endcase
        end
        ocupado_n = (estado_n == CORRE) || (estado_n == PAUSA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= IDLE;
            restante  <= '0;
            tick_r    <= 1'b0;
            fin_r     <= 1'b0;
            ocupado_r <= 1'b0;
        end else begin
            estado    <= estado_n;
            restante  <= restante_n;
            tick_r    <= tick_n;
            fin_r     <= fin_n;
            ocupado_r <= ocupado_n;
        end
    end

`ifdef AUTORELOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carga_reg <= '0;
        end else begin
            carga_reg <= carga_reg_n;
        end
    end
`endif

    assign bus.estado   = estado;
    assign bus.restante = restante;
    assign bus.tick     = tick_r;
    assign bus.fin      = fin_r;
    assign bus.ocupado  = ocupado_r;
endmodule

// File: tb/tb_controlador_temporizador.sv
// Scoreboard bench for controlador_temporizador with PRESCALE=4, CUENTA_W=8.
// Stimulus pushes the expected tick/fin events; a monitor pops one per pulse.
module tb_controlador_temporizador;
    import controlador_pkg::*;

    typedef struct {
        int unsigned cyc;
        logic        tick;
        logic        fin;
        logic [7:0]  rest;
        logic [1:0]  est;
        logic        ocup;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    int unsigned e0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    controlador_temporizador_if #(.CUENTA_W(8)) bus ();

    controlador_temporizador #(.PRESCALE(4), .CUENTA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every tick or fin pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && (bus.tick || bus.fin)) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: cyc=%0d tick=%0b fin=%0b rest=%0d, none required",
                         cyc, bus.tick, bus.fin, bus.restante);
            end else begin
                exp_t e;
                logic [1:0] est;
                e   = sb.pop_front();
                est = bus.estado;
                if (cyc != e.cyc || bus.tick !== e.tick || bus.fin !== e.fin ||
                    bus.restante !== e.rest || est !== e.est || bus.ocupado !== e.ocup) begin
                    n_err++;
                    $display("FAIL event: got cyc=%0d tick=%0b fin=%0b rest=%0d est=%0d ocup=%0b, required cyc=%0d tick=%0b fin=%0b rest=%0d est=%0d ocup=%0b",
                             cyc, bus.tick, bus.fin, bus.restante, est, bus.ocupado,
                             e.cyc, e.tick, e.fin, e.rest, e.est, e.ocup);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic push(input int unsigned c, input logic t, input logic f,
                        input logic [7:0] r, input logic [1:0] s, input logic o);
        exp_t e;
        e.cyc = c; e.tick = t; e.fin = f; e.rest = r; e.est = s; e.ocup = o;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // Issue start for exactly one edge; e0 is the accepting edge's cycle number.
    task automatic do_start(input logic [7:0] n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.carga = n;
        e0 = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_estado"},   int'(bus.estado), 0);
        chk({name, "_restante"}, int'(bus.restante), 0);
        chk({name, "_flags"},    int'({bus.tick, bus.fin, bus.ocupado}), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pausa = 1'b0;
        bus.clear = 1'b0;
        bus.carga = '0;
        #1;
        chk_idle("reset_init");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a run.
        do_start(8'd4);
        @(negedge clk);
        chk("run_before_reset", int'(bus.estado), int'(CORRE));
        #2 rst_n = 1'b0;
        #1 chk_idle("reset_async");
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot, carga=3: ticks at +4, +8, +12, fin with the last one.
        do_start(8'd3);
        push(e0 + 4,  1, 0, 8'd2, 2'(CORRE), 1);
        push(e0 + 8,  1, 0, 8'd1, 2'(CORRE), 1);
        push(e0 + 12, 1, 1, 8'd0, 2'(FIN),   0);
        wait_until(e0 + 2);
        chk("run_ocupado", int'(bus.ocupado), 1);
        chk("run_restante", int'(bus.restante), 3);
        wait_until(e0 + 14);
        chk("oneshot_end_estado", int'(bus.estado), int'(FIN));
        chk("oneshot_drained", sb.size(), 0);

        // Pause freezing 5 prescaler edges after the first tick: fin at +17.
        do_start(8'd3);
        push(e0 + 4,  1, 0, 8'd2, 2'(CORRE), 1);
        push(e0 + 13, 1, 0, 8'd1, 2'(CORRE), 1);
        push(e0 + 17, 1, 1, 8'd0, 2'(FIN),   0);
        wait_until(e0 + 4);
        bus.pausa = 1'b1;
        wait_until(e0 + 7);
        chk("pause_estado", int'(bus.estado), int'(PAUSA));
        chk("pause_restante", int'(bus.restante), 2);
        chk("pause_ocupado", int'(bus.ocupado), 1);
        wait_until(e0 + 8);
        bus.pausa = 1'b0;
        wait_until(e0 + 19);
        chk("pause_drained", sb.size(), 0);

        // start in CORRE is ignored.
        do_start(8'd5);
        wait_until(e0 + 1);
        bus.start = 1'b1;
        bus.carga = 8'd9;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ignored_start_rest", int'(bus.restante), 5);

        // clear with start on the edge where a wrap is due: back to IDLE, no pulse.
        wait_until(e0 + 3);
        bus.clear = 1'b1;
        bus.start = 1'b1;
        bus.carga = 8'd7;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.start = 1'b0;
        chk_idle("clear_start");
        repeat (12) @(negedge clk);
        chk("clear_quiet", sb.size(), 0);
        chk("clear_stays_idle", int'(bus.estado), int'(IDLE));

        // carga=0: straight to FIN with one fin pulse, no tick.
        do_start(8'd0);
        push(e0, 0, 1, 8'd0, 2'(FIN), 0);
        repeat (3) @(negedge clk);
        chk("zero_estado", int'(bus.estado), int'(FIN));
        chk("zero_drained", sb.size(), 0);

        // Restart from FIN with carga=2: fin at +8.
        do_start(8'd2);
        push(e0 + 4, 1, 0, 8'd1, 2'(CORRE), 1);
        push(e0 + 8, 1, 1, 8'd0, 2'(FIN),   0);
        wait_until(e0 + 10);
        chk("restart_drained", sb.size(), 0);
        chk("restart_estado", int'(bus.estado), int'(FIN));

`ifdef AUTORELOAD_EN
        // Auto-reload, carga=2: fin every 8 cycles, restante 1,2,1,2...
        do_start(8'd2);
        push(e0 + 4,  1, 0, 8'd1, 2'(CORRE), 1);
        push(e0 + 8,  1, 1, 8'd2, 2'(CORRE), 1);
        push(e0 + 12, 1, 0, 8'd1, 2'(CORRE), 1);
        push(e0 + 16, 1, 1, 8'd2, 2'(CORRE), 1);
        push(e0 + 20, 1, 0, 8'd1, 2'(CORRE), 1);
        wait_until(e0 + 21);
        chk("reload_ocupado", int'(bus.ocupado), 1);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk_idle("reload_clear");
        repeat (8) @(negedge clk);
        chk("reload_drained", sb.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
